// File: rtl/mod13_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module   : mod13_updown_counter
//  Brief    : 4-bit modulo-13 up/down counter with synchronous parallel load.
//             Counts 0..12, wrapping in both directions. Load has priority
//             over counting; an out-of-range load value (13..15) loads 0.
//             Reset is asynchronous and active-low on port rst.
//  Options  : MOD13_TC_EN - adds the terminal-count output tc, high when the
//             next counting edge will wrap (12 going up, 0 going down).
//  Revision : 1.0 - initial release
// ============================================================================
module mod13_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] count
`ifdef MOD13_TC_EN
  ,
  output logic             tc
`endif
);

  // Largest legal count value and the unit step.
  localparam logic [WIDTH-1:0] c_count_max = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] c_one       = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             w_load_legal;
  logic             w_state_legal;

  // An out-of-range parallel-load value is replaced by 0 rather than loaded.
  assign w_load_legal  = (data_in <= c_count_max);
  // Values 13..15 cannot be reached, but if one ever appears (e.g. an upset)
  // the next counting edge steers the counter back to 0.
  assign w_state_legal = (count_q <= c_count_max);

  // Next-state selection: load first, then recovery, then up/down with wrap.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = w_load_legal ? data_in : '0;
    end else if (!w_state_legal) begin
      count_d = '0;
    end else if (mode) begin
      count_d = (count_q == c_count_max) ? '0 : (count_q + c_one);
    end else begin
      count_d = (count_q == '0) ? c_count_max : (count_q - c_one);
    end
  end

  // State register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

`ifdef MOD13_TC_EN
  logic w_tc_wrap;

  // Flags that the next counting edge wraps; forced low while in reset.
  assign w_tc_wrap = mode ? (count_q == c_count_max) : (count_q == '0);
  assign tc        = rst & w_tc_wrap;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mod13_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mod13_updown_counter
//  Brief    : Directed and randomised self-checking bench for the modulo-13
//             up/down counter. Checks tc as well when MOD13_TC_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mod13_updown_counter;

  logic       clk;
  logic       rst;
  logic       mode;
  logic       load;
  logic [3:0] data_in;
  logic [3:0] count;
`ifdef MOD13_TC_EN
  logic       tc;
`endif

  int n_checks;
  int n_fail;

  mod13_updown_counter #(
    .WIDTH   (4),
    .MODULUS (13)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .mode    (mode),
    .load    (load),
    .data_in (data_in),
    .count   (count)
`ifdef MOD13_TC_EN
    ,
    .tc      (tc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference next-state for the random run.
  function automatic logic [3:0] ref_next(input logic [3:0] cur, input logic m,
                                          input logic ld, input logic [3:0] d);
    if (ld)           return (d > 4'd12) ? 4'd0 : d;
    if (cur > 4'd12)  return 4'd0;
    if (m)            return (cur == 4'd12) ? 4'd0 : 4'(cur + 4'd1);
    return (cur == 4'd0) ? 4'd12 : 4'(cur - 4'd1);
  endfunction

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; load = 1'b0; data_in = 4'd0;
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (count !== 4'd0) begin
      n_fail++; $display("FAIL reset_initial: count=%0d expected 0", count);
    end
`ifdef MOD13_TC_EN
    n_checks++;
    if (tc !== 1'b0) begin
      n_fail++; $display("FAIL reset_tc_low: tc=%b expected 0", tc);
    end
`endif
    // Leave reset and load 7.
    tick();
    rst = 1'b1; load = 1'b1; data_in = 4'd7;
    tick();
    n_checks++;
    if (count !== 4'd7) begin
      n_fail++; $display("FAIL reset_preload7: count=%0d expected 7", count);
    end
    // Mid-cycle asynchronous reset, well before the next edge.
    #3 rst = 1'b0;
    #1;
    n_checks++;
    if (count !== 4'd0) begin
      n_fail++; $display("FAIL reset_async_clear: count=%0d expected 0", count);
    end
    tick();
    n_checks++;
    if (count !== 4'd0) begin
      n_fail++; $display("FAIL reset_hold: count=%0d expected 0", count);
    end
    // Release with mode=1, load=0: 1,2,3 on following edges.
    rst = 1'b1; load = 1'b0; mode = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++;
      if (count !== 4'(i)) begin
        n_fail++; $display("FAIL reset_release_step%0d: count=%0d expected %0d", i, count, i);
      end
    end
  endtask

  task automatic test_up_wrap();
    logic [3:0] exp_seq [4] = '{4'd11, 4'd12, 4'd0, 4'd1};
    load = 1'b1; data_in = 4'd10; mode = 1'b0;
    tick();
    n_checks++;
    if (count !== 4'd10) begin
      n_fail++; $display("FAIL up_load10: count=%0d expected 10", count);
    end
    load = 1'b0; mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef MOD13_TC_EN
      n_checks++;
      if (tc !== (count == 4'd12)) begin
        n_fail++; $display("FAIL up_tc%0d: tc=%b count=%0d", i, tc, count);
      end
`endif
      tick();
      n_checks++;
      if (count !== exp_seq[i]) begin
        n_fail++; $display("FAIL up_wrap%0d: count=%0d expected %0d", i, count, exp_seq[i]);
      end
    end
  endtask

  task automatic test_down_wrap();
    logic [3:0] exp_seq [4] = '{4'd1, 4'd0, 4'd12, 4'd11};
    load = 1'b1; data_in = 4'd2; mode = 1'b1;
    tick();
    n_checks++;
    if (count !== 4'd2) begin
      n_fail++; $display("FAIL down_load2: count=%0d expected 2", count);
    end
    load = 1'b0; mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
`ifdef MOD13_TC_EN
      n_checks++;
      if (tc !== (count == 4'd0)) begin
        n_fail++; $display("FAIL down_tc%0d: tc=%b count=%0d", i, tc, count);
      end
`endif
      tick();
      n_checks++;
      if (count !== exp_seq[i]) begin
        n_fail++; $display("FAIL down_wrap%0d: count=%0d expected %0d", i, count, exp_seq[i]);
      end
    end
  endtask

  task automatic test_load_priority();
    logic [3:0] vals [5] = '{4'd14, 4'd12, 4'd13, 4'd15, 4'd0};
    logic       mds  [5] = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b0};
    logic [3:0] exps [5] = '{4'd0,  4'd12, 4'd0,  4'd0,  4'd0};
    // Start from a non-zero value so an illegal load to 0 is visible.
    load = 1'b1; data_in = 4'd6; mode = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      data_in = vals[i]; mode = mds[i];
      tick();
      n_checks++;
      if (count !== exps[i]) begin
        n_fail++; $display("FAIL load_d%0d_m%0d: count=%0d expected %0d", vals[i], mds[i], count, exps[i]);
      end
      // Re-seed 6 between vectors.
      data_in = 4'd6;
      tick();
    end
    load = 1'b0;
  endtask

  task automatic test_direction_change();
    logic [3:0] exp_seq [5] = '{4'd6, 4'd7, 4'd6, 4'd5, 4'd4};
    load = 1'b1; data_in = 4'd5; mode = 1'b0;
    tick();
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mode = (i < 2);
      tick();
      n_checks++;
      if (count !== exp_seq[i]) begin
        n_fail++; $display("FAIL dirchg%0d: count=%0d expected %0d", i, count, exp_seq[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] model;
    model = count;
    for (int i = 0; i < 100; i++) begin
      rst     = ($urandom_range(0, 9) != 0);
      mode    = 1'($urandom);
      load    = ($urandom_range(0, 3) == 0);
      data_in = 4'($urandom);
      if (!rst) model = 4'd0;
      #1;
      n_checks++;
      if (count !== model) begin
        n_fail++; $display("FAIL rand%0d_pre: count=%0d expected %0d", i, count, model);
      end
`ifdef MOD13_TC_EN
      n_checks++;
      if (tc !== (rst && (mode ? (model == 4'd12) : (model == 4'd0)))) begin
        n_fail++; $display("FAIL rand%0d_tc: tc=%b count=%0d mode=%b rst=%b", i, tc, model, mode, rst);
      end
`endif
      @(posedge clk);
      if (rst) model = ref_next(model, mode, load, data_in);
      #1;
      n_checks++;
      if (count !== model) begin
        n_fail++; $display("FAIL rand%0d: count=%0d expected %0d", i, count, model);
      end
    end
    rst = 1'b1; load = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_priority();
    test_direction_change();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 ns");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
